ifetch_prefetch_q: RTL and testbench

//  Parametrised instruction-fetch unit with a prefetch queue. It issues sequential word

---
 rtl/ifetch_prefetch_q.sv | 139 +++++++++++++
 tb/tb_ifetch_prefetch_q.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch_q.sv
// Instruction fetch unit: issues sequential word fetches to a 1-cycle program ROM and
// buffers {pc, instruction} pairs in a DEPTH-entry prefetch queue presented to ID.
module ifetch_prefetch_q #(
    parameter int          ROM_AW   = 14,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ROM_AW-1:0] rom_adr_o,
    output logic              rom_en_o,
    input  logic [31:0]       Jpadr,
    input  logic              nBranch,
    input  logic [31:0]       id_target,
    input  logic              JR,
    input  logic [31:0]       Read_data_1,
    input  logic              J,
    input  logic [25:0]       Jump_PC,
    input  logic              flush,
    input  logic [31:0]       interrupt_PC,
    input  logic              bp_taken,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       Instruction,
    output logic [31:0]       inst_pc,
    output logic [31:0]       opcplus4
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q;
    logic [31:0]   inflight_pc_q;
    logic          inflight_q;
    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_after_pop;
    logic [CW:0]   credits_used;
    logic          pop;
    logic          push;
    logic          issue;
    logic          bp_redirect;
    logic          redirect;
    logic [31:0]   bp_target;
    logic [31:0]   redirect_target;

    function automatic logic [31:0] link_word(input logic [31:0] pc);
        logic [31:0] pc_plus4;
        pc_plus4 = pc + 32'd4;
        return {2'b00, pc_plus4[31:2]};
    endfunction

    assign pop         = inst_valid & inst_ready;
    assign bp_redirect = bp_taken & pop;
    assign redirect    = nBranch | JR | J | bp_redirect | flush;
    assign bp_target   = inst_pc + 32'd4 + {{14{Instruction[15]}}, Instruction[15:0], 2'b00};

    always_comb begin
        if (nBranch)          redirect_target = id_target;
        else if (JR)          redirect_target = Read_data_1;
        else if (J)           redirect_target = {fetch_pc_q[31:28], Jump_PC, 2'b00};
        else if (bp_redirect) redirect_target = bp_target;
        else                  redirect_target = interrupt_PC;
    end

    // A fetch is only issued when a queue slot is guaranteed for its return next cycle.
    assign credits_used    = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign issue           = ~reset & ~redirect & (credits_used < (CW+1)'(DEPTH));
    assign push            = inflight_q & ~redirect;
    assign count_after_pop = count_q - CW'(pop);
    assign rd_ptr_next     = rd_ptr_q + PW'(pop);

    assign rom_adr_o = fetch_pc_q[ROM_AW+1:2];
    assign rom_en_o  = issue;

    // NOTE: every register here is assigned with <= so all of them sample pre-edge values.
    always_ff @(negedge clock) begin
        if (reset) begin
            fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inst_valid    <= 1'b0;
            Instruction   <= '0;
            inst_pc       <= '0;
            opcplus4      <= '0;
        end else if (redirect) begin
            fetch_pc_q <= redirect_target & ~32'h3;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inst_valid <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                fetch_pc_q    <= fetch_pc_q + 32'd4;
                inflight_pc_q <= fetch_pc_q;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            rd_ptr_q <= rd_ptr_next;
            count_q  <= count_after_pop + CW'(push);

            // Head registers track the next head; when the queue drains they hold.
            if (count_after_pop != '0) begin
                inst_valid  <= 1'b1;
                Instruction <= mem_instr[rd_ptr_next];
                inst_pc     <= mem_pc[rd_ptr_next];
                opcplus4    <= link_word(mem_pc[rd_ptr_next]);
            end else if (push) begin
                inst_valid  <= 1'b1;
                Instruction <= Jpadr;
                inst_pc     <= inflight_pc_q;
                opcplus4    <= link_word(inflight_pc_q);
            end else begin
                inst_valid <= 1'b0;
            end
        end
    end

    // NOTE: queue storage has no reset; count_q and inst_valid decide which entries are live.
    always_ff @(negedge clock) begin
        if (push && !reset) begin
            mem_instr[wr_ptr_q] <= Jpadr;
            mem_pc[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    queue_no_overflow: assert property (@(negedge clock) disable iff (reset)
        !(push && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_ifetch_prefetch_q.sv
// Directed bench for ifetch_prefetch_q: a ROM model answers fetches, a scoreboard of
// expected {pc, instruction} pairs is drained by a monitor on every ID handshake.
module tb_ifetch_prefetch_q;
    localparam int ROM_AW = 14;
    localparam int DEPTH  = 4;

    logic              clock        = 1'b0;
    logic              reset        = 1'b1;
    logic [ROM_AW-1:0] rom_adr_o;
    logic              rom_en_o;
    logic [31:0]       Jpadr        = '0;
    logic              nBranch      = 1'b0;
    logic [31:0]       id_target    = '0;
    logic              JR           = 1'b0;
    logic [31:0]       Read_data_1  = '0;
    logic              J            = 1'b0;
    logic [25:0]       Jump_PC      = '0;
    logic              flush        = 1'b0;
    logic [31:0]       interrupt_PC = '0;
    logic              bp_taken     = 1'b0;
    logic              inst_valid;
    logic              inst_ready   = 1'b0;
    logic [31:0]       Instruction;
    logic [31:0]       inst_pc;
    logic [31:0]       opcplus4;

    always #5 clock = ~clock;

    ifetch_prefetch_q #(.ROM_AW(ROM_AW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset),
        .rom_adr_o(rom_adr_o), .rom_en_o(rom_en_o), .Jpadr(Jpadr),
        .nBranch(nBranch), .id_target(id_target),
        .JR(JR), .Read_data_1(Read_data_1),
        .J(J), .Jump_PC(Jump_PC),
        .flush(flush), .interrupt_PC(interrupt_PC),
        .bp_taken(bp_taken),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .Instruction(Instruction), .inst_pc(inst_pc), .opcplus4(opcplus4)
    );

    // Program ROM with one cycle of read latency.
    logic [31:0] rom [1 << ROM_AW];
    always @(negedge clock) if (rom_en_o) Jpadr <= rom[rom_adr_o];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start_pc, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc    = start_pc + 32'(4 * i);
            e.instr = rom[e.pc[ROM_AW+1:2]];
            sb.push_back(e);
        end
    endtask

    // Cycles run negedge to negedge; inputs change just after the edge.
    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic do_reset;
        inst_ready = 1'b0;
        nBranch    = 1'b0;
        JR         = 1'b0;
        J          = 1'b0;
        flush      = 1'b0;
        bp_taken   = 1'b0;
        reset      = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // Monitor: every accepted head must be the next expected pair.
    always @(posedge clock) begin
        if (!reset && inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected delivery: got pc %h, required no delivery", inst_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("delivered pc", inst_pc, e.pc);
                check("delivered instruction", Instruction, e.instr);
                check("delivered opcplus4", opcplus4, (e.pc >> 2) + 32'd1);
            end
        end
    end

    initial begin
        repeat (3000) @(negedge clock);
        $display("FAIL watchdog: bench still running after 3000 cycles, required to finish");
        $fatal(1, "timeout");
    end

    initial begin
        int issued;
        for (int i = 0; i < (1 << ROM_AW); i++) rom[i] = 32'(i);

        // Reset state
        tick;
        tick;
        settle;
        check("reset inst_valid", 32'(inst_valid), 32'd0);
        check("reset rom_en_o", 32'(rom_en_o), 32'd0);
        check("reset Instruction", Instruction, 32'd0);
        check("reset inst_pc", inst_pc, 32'd0);
        check("reset opcplus4", opcplus4, 32'd0);
        tick;
        reset      = 1'b0;
        inst_ready = 1'b1;

        // Streaming: one fetch and one delivery per cycle, first delivery at cycle 2
        expect_seq(32'h0, 6);
        for (int c = 0; c < 8; c++) begin
            settle;
            check("stream rom_en_o", 32'(rom_en_o), 32'd1);
            check("stream rom_adr_o", 32'(rom_adr_o), 32'(c));
            if (c < 2) check("stream early inst_valid", 32'(inst_valid), 32'd0);
            else if (c == 2) check("stream first inst_valid", 32'(inst_valid), 32'd1);
            tick;
        end
        inst_ready = 1'b0;

        // Stall: exactly DEPTH fetches, then drain without gaps
        do_reset;
        expect_seq(32'h0, 8);
        issued = 0;
        for (int c = 0; c < 10; c++) begin
            settle;
            issued += int'(rom_en_o);
            if (c == 9) check("stall rom_en_o when full", 32'(rom_en_o), 32'd0);
            tick;
        end
        check("stall fetches issued", 32'(issued), 32'(DEPTH));
        inst_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            settle;
            if (c < 4) check("drain inst_valid no gap", 32'(inst_valid), 32'd1);
            tick;
        end
        inst_ready = 1'b0;

        // JR with a fetch in flight: that return is dropped
        do_reset;
        expect_seq(32'h100, 3);
        inst_ready = 1'b1;
        settle;
        check("jr pre rom_adr_o", 32'(rom_adr_o), 32'd0);
        tick;
        JR          = 1'b1;
        Read_data_1 = 32'h103;
        settle;
        check("jr redirect rom_en_o", 32'(rom_en_o), 32'd0);
        tick;
        JR = 1'b0;
        settle;
        check("jr inst_valid after", 32'(inst_valid), 32'd0);
        check("jr target rom_en_o", 32'(rom_en_o), 32'd1);
        check("jr target rom_adr_o", 32'(rom_adr_o), 32'h40);
        tick;
        run(1);
        settle;
        check("jr target inst_valid", 32'(inst_valid), 32'd1);
        tick;
        run(2);
        inst_ready = 1'b0;

        // nBranch beats J, then flush alone
        do_reset;
        expect_seq(32'h0, 2);
        expect_seq(32'h200, 4);
        expect_seq(32'h380, 4);
        inst_ready = 1'b1;
        run(4);
        inst_ready = 1'b0;
        nBranch    = 1'b1;
        id_target  = 32'h200;
        J          = 1'b1;
        Jump_PC    = 26'h100;
        settle;
        check("nbranch redirect rom_en_o", 32'(rom_en_o), 32'd0);
        tick;
        nBranch    = 1'b0;
        J          = 1'b0;
        inst_ready = 1'b1;
        settle;
        check("nbranch target rom_adr_o", 32'(rom_adr_o), 32'h80);
        tick;
        run(5);
        inst_ready   = 1'b0;
        flush        = 1'b1;
        interrupt_PC = 32'h380;
        settle;
        check("flush redirect rom_en_o", 32'(rom_en_o), 32'd0);
        tick;
        flush      = 1'b0;
        inst_ready = 1'b1;
        settle;
        check("flush target rom_adr_o", 32'(rom_adr_o), 32'hE0);
        tick;
        run(5);
        inst_ready = 1'b0;

        // Predicted-taken backward branch at 0x10 to 0x04
        rom[4] = 32'h1000_FFFC;
        do_reset;
        expect_seq(32'h0, 5);
        expect_seq(32'h4, 3);
        inst_ready = 1'b1;
        run(6);
        bp_taken = 1'b1;
        settle;
        check("bp head inst_pc", inst_pc, 32'h10);
        check("bp redirect rom_en_o", 32'(rom_en_o), 32'd0);
        tick;
        bp_taken = 1'b0;
        settle;
        check("bp inst_valid after", 32'(inst_valid), 32'd0);
        check("bp target rom_adr_o", 32'(rom_adr_o), 32'h1);
        tick;
        run(4);
        inst_ready = 1'b0;
        rom[4] = 32'd4;

        // Reset with the queue filling and a return in flight
        do_reset;
        expect_seq(32'h0, 2);
        run(4);
        reset = 1'b1;
        settle;
        check("mid reset rom_en_o", 32'(rom_en_o), 32'd0);
        tick;
        reset      = 1'b0;
        inst_ready = 1'b1;
        settle;
        check("post reset inst_valid", 32'(inst_valid), 32'd0);
        check("post reset rom_en_o", 32'(rom_en_o), 32'd1);
        check("post reset rom_adr_o", 32'(rom_adr_o), 32'd0);
        tick;
        run(3);
        inst_ready = 1'b0;
        run(2);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
